// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the data memory and dmem_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic              m0_gnt_o;
  logic              m0_done_o;
  logic              m0_err_o;
  logic [DATA_W-1:0] m0_rdata_o;

  logic              m1_req_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic              m1_gnt_o;
  logic              m1_done_o;
  logic              m1_err_o;
  logic [DATA_W-1:0] m1_rdata_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              cpu_stall_o;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m0_gnt_o, m0_done_o, m0_err_o, m0_rdata_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output m1_gnt_o, m1_done_o, m1_err_o, m1_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    output cpu_stall_o
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m0_gnt_o, m0_done_o, m0_err_o, m0_rdata_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  m1_gnt_o, m1_done_o, m1_err_o, m1_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    input  cpu_stall_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter: round-robin or fixed-priority grant, per-access
// issue/wait/response sequencing, alignment and range checking, CPU stall.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_BYTES  = 128,
  parameter int unsigned MEM_LAT    = 0,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned       CNT_W   = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [ADDR_W-1:0] MEM_TOP = ADDR_W'(MEM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        rerr_q, rerr_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_ok;
  logic              fin;

  // Winner selection and access check on the candidate's live inputs
  always_comb begin
    if (bus.m0_req_i && bus.m1_req_i) begin
      sel = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    end else begin
      sel = ~bus.m0_req_i;
    end
    sel_we    = sel ? bus.m1_we_i    : bus.m0_we_i;
    sel_addr  = sel ? bus.m1_addr_i  : bus.m0_addr_i;
    sel_wdata = sel ? bus.m1_wdata_i : bus.m0_wdata_i;
    sel_ok    = (sel_addr[1:0] == 2'b00) && (sel_addr < MEM_TOP);
  end

  // Next state; output pulses are precomputed so they appear registered in their state
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    we_d        = we_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    gnt_d       = 2'b00;
    done_d      = 2'b00;
    rerr_d      = 2'b00;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    fin         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.m0_req_i || bus.m1_req_i) begin
          state_d     = S_ISSUE;
          win_d       = sel;
          last_d      = sel;
          we_d        = sel_we;
          err_d       = ~sel_ok;
          gnt_d       = {sel, ~sel};
          mem_en_d    = sel_ok;
          mem_we_d    = sel_ok & sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
        end
      end
      S_ISSUE: begin
        if (err_q || we_q || (MEM_LAT == 0)) begin
          fin = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(MEM_LAT);
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          fin = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (fin) begin
      state_d = S_RESP;
      done_d  = {win_q, ~win_q};
      rerr_d  = {win_q & err_q, ~win_q & err_q};
      if (!err_q && !we_q) begin
        if (win_q) begin
          rdata1_d = bus.mem_rdata_i;
        end else begin
          rdata0_d = bus.mem_rdata_i;
        end
      end
    end
  end

  // State and output registers; reset leaves port 0 winning the first tie
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      rerr_q      <= 2'b00;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      we_q        <= we_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rerr_q      <= rerr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign bus.m0_gnt_o    = gnt_q[0];
  assign bus.m1_gnt_o    = gnt_q[1];
  assign bus.m0_done_o   = done_q[0];
  assign bus.m1_done_o   = done_q[1];
  assign bus.m0_err_o    = rerr_q[0];
  assign bus.m1_err_o    = rerr_q[1];
  assign bus.m0_rdata_o  = rdata0_q;
  assign bus.m1_rdata_o  = rdata1_q;
  assign bus.mem_en_o    = mem_en_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.cpu_stall_o = bus.m0_req_i & ~done_q[0];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a zero-latency round-robin instance driven from a
// cycle table, and a two-cycle-latency fixed-priority instance driven by hand sequences.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [8:0] G0 = 9'h100, G1 = 9'h080, D0 = 9'h040, D1 = 9'h020,
                         E0 = 9'h010, E1 = 9'h008, EN = 9'h004, WE = 9'h002, ST = 9'h001;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifb ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(128), .MEM_LAT(0), .FIXED_PRIO(0))
    dut_a (.clk_i(clk), .rst_i(rst_a), .bus(ifa));
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(128), .MEM_LAT(2), .FIXED_PRIO(1))
    dut_b (.clk_i(clk), .rst_i(rst_b), .bus(ifb));

  function automatic logic [31:0] init_word(input logic [4:0] idx);
    return (idx == 5'd2) ? 32'h0000_1234 : (32'hC0DE_0000 | 32'(idx));
  endfunction

  // Memory A: combinational read
  logic [31:0] mema [32];
  logic        wra  [32];
  logic [4:0]  ia;
  assign ia = ifa.mem_addr_o[6:2];
  assign ifa.mem_rdata_i = wra[ia] ? mema[ia] : init_word(ia);
  always @(posedge clk) begin
    if (rst_a) begin
      for (int i = 0; i < 32; i++) wra[i] <= 1'b0;
    end else if (ifa.mem_en_o && ifa.mem_we_o) begin
      mema[ia] <= ifa.mem_wdata_o;
      wra[ia]  <= 1'b1;
    end
  end

  // Memory B: read data valid only in the second cycle after the strobe
  logic [31:0] memb [32];
  logic        wrb  [32];
  logic [4:0]  ib;
  logic [31:0] rdb_now, db1, db2;
  logic        vb1, vb2;
  assign ib      = ifb.mem_addr_o[6:2];
  assign rdb_now = wrb[ib] ? memb[ib] : init_word(ib);
  assign ifb.mem_rdata_i = vb2 ? db2 : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (rst_b) begin
      for (int i = 0; i < 32; i++) wrb[i] <= 1'b0;
    end else if (ifb.mem_en_o && ifb.mem_we_o) begin
      memb[ib] <= ifb.mem_wdata_o;
      wrb[ib]  <= 1'b1;
    end
    vb1 <= ifb.mem_en_o & ~ifb.mem_we_o;
    db1 <= rdb_now;
    vb2 <= vb1;
    db2 <= db1;
  end

  function automatic logic [8:0] fa();
    return {ifa.m0_gnt_o, ifa.m1_gnt_o, ifa.m0_done_o, ifa.m1_done_o, ifa.m0_err_o,
            ifa.m1_err_o, ifa.mem_en_o, ifa.mem_we_o, ifa.cpu_stall_o};
  endfunction

  function automatic logic [8:0] fb();
    return {ifb.m0_gnt_o, ifb.m1_gnt_o, ifb.m0_done_o, ifb.m1_done_o, ifb.m0_err_o,
            ifb.m1_err_o, ifb.mem_en_o, ifb.mem_we_o, ifb.cpu_stall_o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic [8:0]  ef;
    logic [31:0] ema, erd0, erd1;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic rst, input logic r0, input logic w0, input logic [31:0] a0,
                     input logic [31:0] d0, input logic r1, input logic w1,
                     input logic [31:0] a1, input logic [31:0] d1, input logic [8:0] ef,
                     input logic [31:0] ema, input logic [31:0] erd0, input logic [31:0] erd1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.ef = ef; v.ema = ema; v.erd0 = erd0; v.erd1 = erd1;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t  v;
    int    lat;
    logic  got;
    logic  saw;
    int    n0;
    int    order[$];

    rst_a = 1'b1; rst_b = 1'b1;
    ifa.m0_req_i = 0; ifa.m0_we_i = 0; ifa.m0_addr_i = 0; ifa.m0_wdata_i = 0;
    ifa.m1_req_i = 0; ifa.m1_we_i = 0; ifa.m1_addr_i = 0; ifa.m1_wdata_i = 0;
    ifb.m0_req_i = 0; ifb.m0_we_i = 0; ifb.m0_addr_i = 0; ifb.m0_wdata_i = 0;
    ifb.m1_req_i = 0; ifb.m1_we_i = 0; ifb.m1_addr_i = 0; ifb.m1_wdata_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a.flags", 32'(fa()), 32'h0);
    chk("rst_a.rdata0", ifa.m0_rdata_o, 32'h0);
    chk("rst_a.rdata1", ifa.m1_rdata_o, 32'h0);
    chk("rst_a.mem_addr", ifa.mem_addr_o, 32'h0);
    chk("rst_b.flags", 32'(fb()), 32'h0);
    chk("rst_b.rdata0", ifb.m0_rdata_o, 32'h0);

    //  rst r0 w0 a0           d0     r1 w1 a1           d1  flags          ema  rd0          rd1
    add(0, 1, 0, 8,           0,     0, 0, 0,           0,  ST,            0,   0,           0);
    add(0, 1, 0, 8,           0,     0, 0, 0,           0,  G0|EN|ST,      8,   0,           0);
    add(0, 1, 0, 8,           0,     0, 0, 0,           0,  D0,            0,   32'h1234,    0);
    add(1, 0, 0, 0,           0,     0, 0, 0,           0,  9'h0,          0,   32'h1234,    0);
    add(0, 1, 1, 4,           'hAA,  1, 0, 4,           0,  ST,            0,   0,           0);
    add(0, 1, 1, 4,           'hAA,  1, 0, 4,           0,  G0|EN|WE|ST,   4,   0,           0);
    add(0, 1, 1, 4,           'hAA,  1, 0, 4,           0,  D0,            0,   0,           0);
    add(0, 1, 0, 4,           0,     1, 0, 4,           0,  ST,            0,   0,           0);
    add(0, 1, 0, 4,           0,     1, 0, 4,           0,  G1|EN|ST,      4,   0,           0);
    add(0, 1, 0, 4,           0,     1, 0, 4,           0,  D1|ST,         0,   0,           'hAA);
    add(0, 1, 0, 4,           0,     0, 0, 0,           0,  ST,            0,   0,           'hAA);
    add(0, 1, 0, 4,           0,     0, 0, 0,           0,  G0|EN|ST,      4,   0,           'hAA);
    add(0, 1, 0, 4,           0,     0, 0, 0,           0,  D0,            0,   'hAA,        'hAA);
    add(0, 0, 0, 0,           0,     0, 0, 0,           0,  9'h0,          0,   'hAA,        'hAA);
    add(0, 0, 0, 0,           0,     1, 0, 6,           0,  9'h0,          0,   'hAA,        'hAA);
    add(0, 0, 0, 0,           0,     1, 0, 6,           0,  G1,            0,   'hAA,        'hAA);
    add(0, 0, 0, 0,           0,     1, 0, 6,           0,  D1|E1,         0,   'hAA,        'hAA);
    add(0, 0, 0, 0,           0,     1, 0, 128,         0,  9'h0,          0,   'hAA,        'hAA);
    add(0, 0, 0, 0,           0,     1, 0, 128,         0,  G1,            0,   'hAA,        'hAA);
    add(0, 0, 0, 0,           0,     1, 0, 128,         0,  D1|E1,         0,   'hAA,        'hAA);
    add(0, 0, 0, 0,           0,     1, 0, 'h8000_0008, 0,  9'h0,          0,   'hAA,        'hAA);
    add(0, 0, 0, 0,           0,     1, 0, 'h8000_0008, 0,  G1,            0,   'hAA,        'hAA);
    add(0, 0, 0, 0,           0,     1, 0, 'h8000_0008, 0,  D1|E1,         0,   'hAA,        'hAA);
    add(0, 0, 0, 0,           0,     0, 0, 0,           0,  9'h0,          0,   'hAA,        'hAA);
    add(0, 1, 0, 8,           0,     0, 0, 0,           0,  ST,            0,   'hAA,        'hAA);
    add(0, 1, 0, 12,          0,     1, 0, 0,           0,  G0|EN|ST,      8,   'hAA,        'hAA);
    add(0, 1, 0, 12,          0,     1, 0, 0,           0,  D0,            0,   32'h1234,    'hAA);
    add(0, 1, 0, 12,          0,     1, 0, 0,           0,  ST,            0,   32'h1234,    'hAA);
    add(0, 1, 0, 12,          0,     1, 0, 0,           0,  G1|EN|ST,      0,   32'h1234,    'hAA);
    add(0, 1, 0, 12,          0,     1, 0, 0,           0,  D1|ST,         0,   32'h1234,    'hC0DE_0000);
    add(0, 1, 0, 12,          0,     0, 0, 0,           0,  ST,            0,   32'h1234,    'hC0DE_0000);
    add(0, 1, 0, 12,          0,     0, 0, 0,           0,  G0|EN|ST,      12,  32'h1234,    'hC0DE_0000);
    add(0, 1, 0, 12,          0,     0, 0, 0,           0,  D0,            0,   'hC0DE_0003, 'hC0DE_0000);
    add(0, 1, 0, 16,          0,     0, 0, 0,           0,  ST,            0,   'hC0DE_0003, 'hC0DE_0000);
    add(0, 1, 0, 16,          0,     0, 0, 0,           0,  G0|EN|ST,      16,  'hC0DE_0003, 'hC0DE_0000);
    add(0, 1, 0, 16,          0,     0, 0, 0,           0,  D0,            0,   'hC0DE_0004, 'hC0DE_0000);
    add(0, 0, 0, 0,           0,     0, 0, 0,           0,  9'h0,          0,   'hC0DE_0004, 'hC0DE_0000);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst_a = v.rst;
      ifa.m0_req_i = v.r0; ifa.m0_we_i = v.w0; ifa.m0_addr_i = v.a0; ifa.m0_wdata_i = v.d0;
      ifa.m1_req_i = v.r1; ifa.m1_we_i = v.w1; ifa.m1_addr_i = v.a1; ifa.m1_wdata_i = v.d1;
      #1;
      chk($sformatf("v%0d.flags", i), 32'(fa()), 32'(v.ef));
      if (v.ef[2]) chk($sformatf("v%0d.mem_addr", i), ifa.mem_addr_o, v.ema);
      chk($sformatf("v%0d.rdata0", i), ifa.m0_rdata_o, v.erd0);
      chk($sformatf("v%0d.rdata1", i), ifa.m1_rdata_o, v.erd1);
      @(posedge clk);
      #1;
    end

    // Two-cycle latency read: done four cycles after the request
    rst_b = 1'b0;
    ifb.m0_req_i = 1; ifb.m0_we_i = 0; ifb.m0_addr_i = 12;
    lat = 0; got = 1'b0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        chk("lat.issue", 32'(fb()), 32'(G0 | EN | ST));
        chk("lat.mem_addr", ifb.mem_addr_o, 32'd12);
      end else if (ifb.m0_done_o) begin
        chk("lat.done", 32'(fb()), 32'(D0));
      end else begin
        chk($sformatf("lat.wait%0d", k), 32'(fb()), 32'(ST));
      end
      if (ifb.m0_done_o) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk("lat.cycles", 32'(lat), 32'd4);
    chk("lat.rdata0", ifb.m0_rdata_o, 32'hC0DE_0003);
    ifb.m0_req_i = 0;
    @(posedge clk);
    #1;

    // Fixed priority: port 0 wins both ties, port 1 then reads port 0's data
    ifb.m0_req_i = 1; ifb.m0_we_i = 1; ifb.m0_addr_i = 4; ifb.m0_wdata_i = 32'hAA;
    ifb.m1_req_i = 1; ifb.m1_we_i = 0; ifb.m1_addr_i = 4;
    n0 = 0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      #1;
      if (ifb.m0_gnt_o) order.push_back(0);
      if (ifb.m1_gnt_o) order.push_back(1);
      if (ifb.m0_done_o) begin
        n0++;
        if (n0 == 2) ifb.m0_req_i = 0;
      end
      if (ifb.m1_done_o) begin
        got = 1'b1;
        ifb.m1_req_i = 0;
      end
    end
    chk("prio.grants", 32'(order.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("prio.order%0d", i), (i < order.size()) ? 32'(order[i]) : 32'd9,
          (i < 2) ? 32'd0 : 32'd1);
    end
    chk("prio.rdata1", ifb.m1_rdata_o, 32'hAA);
    @(posedge clk);
    #1;

    // Reset while waiting on read data abandons the access
    ifb.m0_req_i = 1; ifb.m0_we_i = 0; ifb.m0_addr_i = 12;
    @(posedge clk);
    #1;
    chk("rstw.issue", 32'(fb()), 32'(G0 | EN | ST));
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    ifb.m0_req_i = 0;
    @(posedge clk);
    #1;
    chk("rstw.flags", 32'(fb()), 32'h0);
    chk("rstw.rdata0", ifb.m0_rdata_o, 32'h0);
    rst_b = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (ifb.m0_done_o || ifb.m1_done_o || ifb.mem_en_o) saw = 1'b1;
    end
    chk("rstw.quiet", 32'(saw), 32'h0);

    // Fresh write after reset completes in two cycles
    ifb.m1_req_i = 1; ifb.m1_we_i = 1; ifb.m1_addr_i = 20; ifb.m1_wdata_i = 32'h55;
    lat = 0; got = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        chk("post.issue", 32'(fb()), 32'(G1 | EN | WE));
        chk("post.mem_addr", ifb.mem_addr_o, 32'd20);
        chk("post.mem_wdata", ifb.mem_wdata_o, 32'h55);
      end
      if (ifb.m1_done_o) begin
        got = 1'b1;
        lat = k;
        chk("post.done", 32'(fb()), 32'(D1));
      end
    end
    chk("post.cycles", 32'(lat), 32'd2);
    ifb.m1_req_i = 0;
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
